// File: rtl/output_display_if.sv
// output_display_if: capture strobe/byte from the CPU side and the display outputs.
interface output_display_if;
    logic       load;
    logic [7:0] data_in;
    logic       signed_mode;
    logic [7:0] value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] digit_en;
    modport master (output load, data_in, signed_mode, input value, busy, seg, digit_en);
    modport slave (input load, data_in, signed_mode, output value, busy, seg, digit_en);
endinterface

// File: rtl/output_display.sv
// output_display: captures a CPU output byte, converts it to decimal by double-dabble
// and scans sign/hundreds/tens/ones onto a multiplexed 7-segment display.
module output_display #(
    parameter int REFRESH_DIV = 1024
) (
    input logic             clk,
    input logic             rst,
    output_display_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    typedef enum logic {IDLE, CONVERT} state_t;
    state_t        state_q, state_d;
    logic [2:0]    iter_q, iter_d;
    logic [7:0]    mag_q, mag_d, value_q, value_d;
    logic [11:0]   bcd_q, bcd_d, disp_q, disp_d, adj;
    logic          neg_q, neg_d, disp_neg_q, disp_neg_d;
    logic [CW-1:0] ref_q, ref_d;
    logic [1:0]    scan_q, scan_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    den_q, den_d;
    logic          wrap;

    function automatic logic [3:0] dab(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        value_d    = value_q;
        disp_d     = disp_q;
        disp_neg_d = disp_neg_q;
        adj        = {dab(bcd_q[11:8]), dab(bcd_q[7:4]), dab(bcd_q[3:0])};
        if (bus.load) begin
            value_d = bus.data_in;
            neg_d   = bus.signed_mode & bus.data_in[7];
            mag_d   = neg_d ? ~bus.data_in + 8'd1 : bus.data_in;
            bcd_d   = 12'd0;
            iter_d  = 3'd0;
            state_d = CONVERT;
        end else if (state_q == CONVERT) begin
            bcd_d  = 12'({adj, mag_q[7]});
            mag_d  = {mag_q[6:0], 1'b0};
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                state_d    = IDLE;
                disp_d     = 12'({adj, mag_q[7]});
                disp_neg_d = neg_q;
            end
        end
        wrap   = ref_q == CW'(REFRESH_DIV - 1);
        ref_d  = wrap ? '0 : ref_q + CW'(1);
        scan_d = wrap ? scan_q + 2'd1 : scan_q;
        // seg and digit_en both follow scan_q one cycle late, so they always switch together
        seg_d  = scan_q == 2'd0 ? enc(disp_q[3:0]) :
                 scan_q == 2'd1 ? (disp_q[11:4] == 8'd0 ? 7'h00 : enc(disp_q[7:4])) :
                 scan_q == 2'd2 ? (disp_q[11:8] == 4'd0 ? 7'h00 : enc(disp_q[11:8])) :
                 (disp_neg_q ? 7'h40 : 7'h00);
        den_d  = 4'b0001 << scan_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            iter_q     <= 3'd0;
            mag_q      <= 8'd0;
            bcd_q      <= 12'd0;
            neg_q      <= 1'b0;
            value_q    <= 8'd0;
            disp_q     <= 12'd0;
            disp_neg_q <= 1'b0;
            ref_q      <= '0;
            scan_q     <= 2'd0;
            seg_q      <= 7'h3F;
            den_q      <= 4'b0001;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            value_q    <= value_d;
            disp_q     <= disp_d;
            disp_neg_q <= disp_neg_d;
            ref_q      <= ref_d;
            scan_q     <= scan_d;
            seg_q      <= seg_d;
            den_q      <= den_d;
        end
    end

    assign bus.value    = value_q;
    assign bus.busy     = state_q == CONVERT;
    assign bus.seg      = seg_q;
    assign bus.digit_en = den_q;
endmodule

// File: tb/tb_output_display.sv
// tb_output_display: random and directed loads checked every cycle against a decimal-level model.
module tb_output_display;
    localparam int RD = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    output_display_if bus();
    output_display #(.REFRESH_DIV(RD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int k = 0, m_cnt = 0, m_num = 0, m_disp = 0, saw99 = 0;
    bit m_pneg = 0, m_neg = 0, go = 0, watch99 = 0;
    logic [7:0] m_value = 0;
    logic [6:0] e_seg = 7'h3F;
    logic [3:0] e_den = 4'b0001;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] slot_code(input int s, input int n, input bit ng);
        case (s)
            0: return lut[n % 10];
            1: return n >= 10 ? lut[(n / 10) % 10] : 7'h00;
            2: return n >= 100 ? lut[n / 100] : 7'h00;
            default: return ng ? 7'h40 : 7'h00;
        endcase
    endfunction

    // Model: decimal number on display, countdown of conversion cycles, scan from elapsed time.
    always @(posedge clk) begin
        if (rst) begin
            k = 0; m_cnt = 0; m_value = 0; m_disp = 0; m_neg = 0;
            e_seg = 7'h3F; e_den = 4'b0001; go = 1;
        end else begin
            k++;
            e_den = 4'(1 << (((k - 1) / RD) % 4));
            e_seg = slot_code(((k - 1) / RD) % 4, m_disp, m_neg);
            if (bus.load) begin
                m_value = bus.data_in;
                m_pneg = bus.signed_mode && bus.data_in[7];
                m_num = m_pneg ? 256 - int'(bus.data_in) : int'(bus.data_in);
                m_cnt = 8;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_disp = m_num;
                    m_neg = m_pneg;
                end
            end
        end
        #1;
        if (go) begin
            chk("busy", bus.busy, m_cnt > 0);
            chk("value", bus.value, m_value);
            chk("digit_en", bus.digit_en, e_den);
            chk("seg", bus.seg, e_seg);
            if (watch99 && bus.digit_en == 4'b0010 && bus.seg == 7'h6F) saw99++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] d, input logic s);
        @(negedge clk);
        bus.load = 1'b1; bus.data_in = d; bus.signed_mode = s;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        chk("idle_timeout", i < 40, 1);
    endtask

    task automatic check_frame(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] got [4] = '{default: 'x};
        wait_idle();
        for (int i = 0; i < 4 * RD + 4; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) if (bus.digit_en == 4'(1 << j)) got[j] = bus.seg;
        end
        chk({nm, "_ones"}, got[0], e0);
        chk({nm, "_tens"}, got[1], e1);
        chk({nm, "_hund"}, got[2], e2);
        chk({nm, "_sign"}, got[3], e3);
    endtask

    initial begin
        int run;
        bus.load = 1'b0; bus.data_in = 8'h00; bus.signed_mode = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(9);
        rst = 1'b1;
        idle(2);
        chk("rst_digit_en", bus.digit_en, 4'b0001);
        chk("rst_seg", bus.seg, 7'h3F);
        chk("rst_busy", bus.busy, 0);
        chk("rst_value", bus.value, 8'h00);
        rst = 1'b0;

        do_load(8'hFF, 1'b0);
        run = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin run++; @(negedge clk); end
        chk("busy_len_ff", run, 8);
        check_frame("u255", 7'h6D, 7'h6D, 7'h5B, 7'h00);
        do_load(8'hFF, 1'b1);
        check_frame("sm1", 7'h06, 7'h00, 7'h00, 7'h40);
        do_load(8'h80, 1'b1);
        check_frame("sm128", 7'h7F, 7'h5B, 7'h06, 7'h40);
        do_load(8'h07, 1'b0);
        check_frame("u7", 7'h07, 7'h00, 7'h00, 7'h00);
        do_load(8'h0A, 1'b0);
        check_frame("u10", 7'h3F, 7'h06, 7'h00, 7'h00);

        watch99 = 1;
        do_load(8'h63, 1'b0);
        run = 0;
        for (int i = 0; i < 40 && bus.busy; i++) begin
            run++;
            bus.load = (i == 2);
            bus.data_in = 8'h05;
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk("busy_len_restart", run, 11);
        check_frame("u5", 7'h6D, 7'h00, 7'h00, 7'h00);
        watch99 = 0;
        chk("no_99", saw99, 0);

        do_load(8'hC8, 1'b0);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_busy", bus.busy, 0);
        check_frame("after_rst", 7'h3F, 7'h00, 7'h00, 7'h00);
        do_load(8'hC8, 1'b0);
        check_frame("u200", 7'h3F, 7'h3F, 7'h5B, 7'h00);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                bus.load = 1'($urandom_range(0, 1));
                bus.data_in = 8'($urandom);
                @(negedge clk);
                rst = 1'b0;
                bus.load = 1'b0;
            end
            do_load(8'($urandom), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 12));
        end
        wait_idle();
        idle(4 * RD);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
